// File: rtl/frame_burst_reader.sv
// Frame scan-out reader: Avalon-MM burst reads into a fall-through pixel FIFO.
// Define FRAME_BURST_READER_UNDERFLOW_EN to build the saturating starvation counter.
module frame_burst_reader #(
  parameter int unsigned HDISP      = 800,
  parameter int unsigned VDISP      = 480,
  parameter int unsigned BURST      = 16,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] address,
  output logic [6:0]  burstcount,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        readdatavalid,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic [15:0] underflow_cnt
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BeatW = $clog2(BURST) + 1;
  localparam int unsigned ColW  = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int unsigned RowW  = (VDISP > 1) ? $clog2(VDISP) : 1;

  localparam logic [31:0]      LastAddr   = 32'((HDISP * VDISP - BURST) * 4);
  localparam logic [31:0]      BurstBytes = 32'(BURST * 4);
  localparam logic [CntW-1:0]  DepthC     = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0]  BurstC     = CntW'(BURST);
  localparam logic [BeatW-1:0] LastBeat   = BeatW'(BURST - 1);
  localparam logic [ColW-1:0]  LastCol    = ColW'(HDISP - 1);
  localparam logic [RowW-1:0]  LastRow    = RowW'(VDISP - 1);

  typedef enum logic [1:0] {StIdle, StReq, StData} state_e;

  state_e           state_q;
  logic             read_q;
  logic [31:0]      addr_q;
  logic [BeatW-1:0] beat_q;

  logic [CntW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count, free;
  logic [31:0]      mem_q [FIFO_DEPTH];
  logic             push, pop;

  logic [ColW-1:0]  col_q;
  logic [RowW-1:0]  row_q;

  assign count = wr_ptr_q - rd_ptr_q;
  assign free  = DepthC - count;
  // Beats only count while a burst is outstanding; stale beats after reset are dropped.
  assign push  = (state_q == StData) && readdatavalid;
  assign pop   = pix_valid && pix_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      read_q  <= 1'b0;
      addr_q  <= '0;
      beat_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (free >= BurstC) begin
            state_q <= StReq;
            read_q  <= 1'b1;
          end
        end
        StReq: begin
          if (!waitrequest) begin
            state_q <= StData;
            read_q  <= 1'b0;
            beat_q  <= '0;
            addr_q  <= (addr_q == LastAddr) ? 32'd0 : addr_q + BurstBytes;
          end
        end
        StData: begin
          if (readdatavalid) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LastBeat) state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          read_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PtrW-1:0]] <= readdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (pop) begin
      if (col_q == LastCol) begin
        col_q <= '0;
        row_q <= (row_q == LastRow) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

`ifdef FRAME_BURST_READER_UNDERFLOW_EN
  logic [15:0] uf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uf_q <= '0;
    end else if (pix_ready && !pix_valid && (uf_q != 16'hFFFF)) begin
      uf_q <= uf_q + 16'd1;
    end
  end

  assign underflow_cnt = uf_q;
`else
  assign underflow_cnt = 16'd0;
`endif

  assign address    = addr_q;
  assign read       = read_q;
  assign burstcount = 7'(BURST);
  assign pix_valid  = (count != '0);
  assign pix_data   = mem_q[rd_ptr_q[PtrW-1:0]];
  assign pix_sof    = pix_valid && (col_q == '0) && (row_q == '0);
  assign pix_eol    = pix_valid && (col_q == LastCol);

endmodule

// File: doc/frame_burst_reader.md
FRAME_BURST_READER -- requirements
Module: frame_burst_reader

Interface
REQ-001 SHALL have parameter HDISP, default 800, pixels per line.
REQ-002 SHALL have parameter VDISP, default 480, lines per frame.
REQ-003 SHALL have parameter BURST, default 16, words per Avalon-MM read burst (power of 2, 1..64, divides HDISP*VDISP).
REQ-004 SHALL have parameter FIFO_DEPTH, default 64, pixel FIFO entries (power of 2, >= 2*BURST).
REQ-005 SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port address, output, 32, byte offset of the burst within the frame; the downstream SDRAM port adds the frame base.
REQ-008 SHALL have port burstcount, output, 7, constant BURST.
REQ-009 SHALL have port read, output, 1, Avalon-MM read request.
REQ-010 SHALL have port waitrequest, input, 1, Avalon-MM stall.
REQ-011 SHALL have port readdata, input, 32, returned pixel word.
REQ-012 SHALL have port readdatavalid, input, 1, readdata qualifier.
REQ-013 SHALL have port pix_data, output, 32, pixel at FIFO head.
REQ-014 SHALL have port pix_valid, output, 1, FIFO not empty.
REQ-015 SHALL have port pix_ready, input, 1, consumer accepts pix_data this cycle.
REQ-016 SHALL have port pix_sof, output, 1, pix_data is pixel (0,0) of a frame.
REQ-017 SHALL have port pix_eol, output, 1, pix_data is the last pixel of a line.
REQ-018 SHALL have port underflow_cnt, output, 16, starvation counter (see Configuration).

Function
REQ-019 SHALL use a three-state request FSM: IDLE, REQ, DATA.
REQ-020 In IDLE, SHALL enter REQ when FIFO free space minus zero outstanding words >= BURST.
REQ-021 In REQ, SHALL hold read=1 with a stable address until a cycle with waitrequest=0, then go to DATA.
REQ-022 In DATA, SHALL count readdatavalid beats and return to IDLE on beat BURST; read SHALL be 0 in DATA and IDLE.
REQ-023 SHALL allow at most one outstanding burst; free-space check guarantees no FIFO overflow.
REQ-024 SHALL write each readdatavalid beat into the FIFO the same cycle; readdatavalid outside DATA SHALL be ignored.
REQ-025 SHALL advance address by BURST*4 at the accepted request; after word HDISP*VDISP-BURST, address SHALL wrap to 0.
REQ-026 SHALL pop the FIFO when pix_valid and pix_ready are both 1; simultaneous push and pop SHALL keep the occupancy unchanged.
REQ-027 SHALL present FIFO data with zero-cycle read latency (first-word fall-through).
REQ-028 SHALL track output column (0..HDISP-1) and row (0..VDISP-1), advanced per pop, wrapping at frame end.
REQ-029 SHALL assert pix_sof when column=0 and row=0, and pix_eol when column=HDISP-1, both combinationally with pix_valid.
REQ-030 Pixel order SHALL match address order; no pixel dropped or duplicated across frame wrap.

Reset
REQ-031 On reset_n=0, SHALL immediately force read=0, address=0, FSM=IDLE, FIFO empty, pix_valid=0, column=row=0, underflow_cnt=0.
REQ-032 Reset asserted mid-burst SHALL discard the burst; after release, the first request SHALL be at address 0.
REQ-033 burstcount SHALL equal BURST in and out of reset.

Configuration
REQ-034 With macro FRAME_BURST_READER_UNDERFLOW_EN defined, underflow_cnt SHALL increment each cycle pix_ready=1 and pix_valid=0, saturating at 16'hFFFF.
REQ-035 Without FRAME_BURST_READER_UNDERFLOW_EN, underflow_cnt SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-036 Reset release, waitrequest=0, pix_ready=1, one-cycle data latency -> read bursts at 0x0, 0x40, 0x80 ...; first pixel carries pix_sof=1.
REQ-037 waitrequest held 1 for 5 cycles -> read stays 1 and address stays 0x40 for 6 cycles; exactly one request accepted.
REQ-038 pix_ready=0 for the full frame -> exactly FIFO_DEPTH/BURST bursts issued, then read stays 0, no overflow.
REQ-039 HDISP=8, VDISP=2, BURST=4 -> pix_eol on pixels 7 and 15; pixel 16 has pix_sof=1 with data from address 0x0.
REQ-040 reset_n pulsed low after beat 3 of a burst -> FIFO empty, next request address 0x0, late beats ignored.
REQ-041 Macro defined, FIFO empty, pix_ready=1 for 10 cycles -> underflow_cnt=10; macro undefined -> underflow_cnt=0.
